fifo_wr_arbiter: RTL

//   Shares the single write port of one fifo instance among NUM_REQ requesters.

---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 78 +++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester and fifo write-port bundle for fifo_wr_arbiter
//   master: requester/fifo side, drives req, din_bus, last, fifo_full
//   slave : arbiter side, drives gnt, ack, fifo_wr_en, fifo_din, owner, busy
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int data_width = 8,
   parameter int idx_width  = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*data_width-1:0] din_bus;
   logic [NUM_REQ-1:0]            last;
   logic                          fifo_full;
   logic [NUM_REQ-1:0]            gnt;
   logic [NUM_REQ-1:0]            ack;
   logic                          fifo_wr_en;
   logic [data_width-1:0]         fifo_din;
   logic [idx_width-1:0]          owner;
   logic                          busy;
   modport master (
      output req, din_bus, last, fifo_full,
      input  gnt, ack, fifo_wr_en, fifo_din, owner, busy
   );
   modport slave (
      input  req, din_bus, last, fifo_full,
      output gnt, ack, fifo_wr_en, fifo_din, owner, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one fifo write port among NUM_REQ requesters
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of fifo_wr_arbiter_if (req/din_bus/last/fifo_full in,
//              gnt/ack/fifo_wr_en/fifo_din/owner/busy out)
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int data_width = 8,
   parameter int MAX_BURST  = 16,
   parameter int idx_width  = $clog2(NUM_REQ),
   parameter int cnt_width  = $clog2(MAX_BURST) + 1
) (
   input logic               clk,
   input logic               rst,
   fifo_wr_arbiter_if.slave  bus
);
   typedef enum logic {IDLE, BURST} state_t;
   state_t                 r_state, w_state;
   logic [NUM_REQ-1:0]     r_gnt, w_gnt;
   logic [idx_width-1:0]   r_owner, w_owner, r_rr_ptr, w_rr_ptr, w_pick, w_idx;
   logic [cnt_width-1:0]   r_beat_cnt, w_beat_cnt;
   logic                   w_found, w_accept, w_end;
   // scan from farthest to nearest so the requester closest after rr_ptr is the final winner
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_idx = idx_width'((int'(r_rr_ptr) + k) % NUM_REQ);
         if (bus.req[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end
   assign w_accept       = (r_state == BURST) & bus.req[r_owner] & ~bus.fifo_full;
   // a dropped req ends the burst even while the fifo is full
   assign w_end          = (r_state == BURST) & (~bus.req[r_owner] |
                           (w_accept & (bus.last[r_owner] | r_beat_cnt == cnt_width'(MAX_BURST - 1))));
   assign bus.fifo_wr_en = w_accept;
   assign bus.ack        = w_accept ? NUM_REQ'(1) << r_owner : '0;
   assign bus.fifo_din   = (r_state == BURST) ? bus.din_bus[r_owner*data_width +: data_width] : '0;
   assign bus.gnt        = r_gnt;
   assign bus.owner      = r_owner;
   assign bus.busy       = r_state == BURST;
   always_comb begin
      w_state    = r_state;
      w_gnt      = r_gnt;
      w_owner    = r_owner;
      w_rr_ptr   = r_rr_ptr;
      w_beat_cnt = w_accept ? r_beat_cnt + cnt_width'(1) : r_beat_cnt;
      if (r_state == IDLE && w_found) begin
         w_state    = BURST;
         w_gnt      = NUM_REQ'(1) << w_pick;
         w_owner    = w_pick;
         w_beat_cnt = '0;
      end
      if (w_end) begin
         w_state  = IDLE;
         w_gnt    = '0;
         w_rr_ptr = r_owner;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_gnt      <= '0;
         r_owner    <= '0;
         r_rr_ptr   <= idx_width'(NUM_REQ - 1);
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state;
         r_gnt      <= w_gnt;
         r_owner    <= w_owner;
         r_rr_ptr   <= w_rr_ptr;
         r_beat_cnt <= w_beat_cnt;
      end
   end
endmodule
